// File: rtl/pcie_trans_merge.sv
// pcie_trans_merge
// Return-path merge: two producers (D0, D1) each fill a small ingress FIFO,
// a round-robin arbiter moves one word per cycle into a shared egress FIFO,
// and a single consumer pops the egress FIFO into a registered data_out.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   init                : hold FSM in INIT and reload thresholds while high
//   data_in0 / push_D0  : D0 producer word and write strobe
//   data_in1 / push_D1  : D1 producer word and write strobe
//   pop_out             : consumer pop of egress FIFO
//   Umbral_D_prob       : ingress almost-full threshold (count)
//   Umbral_O_prob       : egress almost-full threshold (count)
//   data_out            : last popped egress word (registered)
//   out_can_pop         : egress FIFO non-empty
//   D0_pause, D1_pause  : ingress count >= latched ingress threshold
//   Out_pause           : egress count >= latched egress threshold
//   error_out           : sticky overflow/underflow flag
//   idle_out            : FSM in IDLE
//   state, next_state   : current and combinational next FSM state
module pcie_trans_merge #(
    parameter int BITNUMBER = 6,
    parameter int LENGTH    = 4,
    parameter int IN_ADDR   = 2,
    parameter int OUT_ADDR  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [BITNUMBER-1:0] data_in0,
    input  logic                 push_D0,
    input  logic [BITNUMBER-1:0] data_in1,
    input  logic                 push_D1,
    input  logic                 pop_out,
    input  logic [LENGTH-1:0]    Umbral_D_prob,
    input  logic [LENGTH-1:0]    Umbral_O_prob,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 out_can_pop,
    output logic                 D0_pause,
    output logic                 D1_pause,
    output logic                 Out_pause,
    output logic                 error_out,
    output logic                 idle_out,
    output logic [3:0]           state,
    output logic [3:0]           next_state
);

    localparam int IN_DEPTH  = 1 << IN_ADDR;
    localparam int OUT_DEPTH = 1 << OUT_ADDR;
    localparam logic [IN_ADDR:0]  IN_FULL  = (IN_ADDR+1)'(IN_DEPTH);
    localparam logic [OUT_ADDR:0] OUT_FULL = (OUT_ADDR+1)'(OUT_DEPTH);

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_INIT   = 4'd1,
        ST_IDLE   = 4'd2,
        ST_ACTIVE = 4'd3,
        ST_ERROR  = 4'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [IN_ADDR:0]       cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [IN_ADDR-1:0]     wr0_q, rd0_q, wr1_q, rd1_q;
    logic [OUT_ADDR:0]      cntO_q, cntO_d;
    logic [OUT_ADDR-1:0]    wrO_q, rdO_q;
    logic [LENGTH-1:0]      thrD_q, thrO_q;
    logic                   prio_q;
    logic                   error_q;
    logic [BITNUMBER-1:0]   dout_q;
    logic [BITNUMBER-1:0]   mem0_q [IN_DEPTH];
    logic [BITNUMBER-1:0]   mem1_q [IN_DEPTH];
    logic [BITNUMBER-1:0]   memO_q [OUT_DEPTH];

    logic                   xferOn, empty0, empty1, emptyO;
    logic                   doXfer, srcSel, xfer0, xfer1, doPop;
    logic                   wrEn0, wrEn1, ovf0, ovf1, underflow, errNow;
    logic [BITNUMBER-1:0]   xferData;

    // Datapath enables. Transfers use registered counts, so a word pushed
    // this cycle cannot also be transferred this cycle. A full egress can
    // still accept a word when the consumer frees a slot on the same edge.
    // When only one ingress has data it is served; prio_q only breaks ties.
    always_comb begin
        xferOn    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
        empty0    = (cnt0_q == '0);
        empty1    = (cnt1_q == '0);
        emptyO    = (cntO_q == '0);
        doXfer    = xferOn && (!empty0 || !empty1) && ((cntO_q != OUT_FULL) || pop_out);
        srcSel    = (!empty0 && !empty1) ? prio_q : empty0;
        xfer0     = doXfer && !srcSel;
        xfer1     = doXfer && srcSel;
        doPop     = xferOn && pop_out && !emptyO;
        underflow = xferOn && pop_out && emptyO;
        ovf0      = xferOn && push_D0 && (cnt0_q == IN_FULL) && !xfer0;
        ovf1      = xferOn && push_D1 && (cnt1_q == IN_FULL) && !xfer1;
        wrEn0     = xferOn && push_D0 && !ovf0;
        wrEn1     = xferOn && push_D1 && !ovf1;
        errNow    = ovf0 || ovf1 || underflow;
        xferData  = srcSel ? mem1_q[rd1_q] : mem0_q[rd0_q];
    end

    // Occupancy bookkeeping: simultaneous in/out on one FIFO leaves the count alone.
    always_comb begin
        cnt0_d = cnt0_q;
        if (wrEn0 && !xfer0)
            cnt0_d = cnt0_q + 1'b1;
        else if (!wrEn0 && xfer0)
            cnt0_d = cnt0_q - 1'b1;

        cnt1_d = cnt1_q;
        if (wrEn1 && !xfer1)
            cnt1_d = cnt1_q + 1'b1;
        else if (!wrEn1 && xfer1)
            cnt1_d = cnt1_q - 1'b1;

        cntO_d = cntO_q;
        if (doXfer && !doPop)
            cntO_d = cntO_q + 1'b1;
        else if (!doXfer && doPop)
            cntO_d = cntO_q - 1'b1;
    end

    // Control FSM next state. ACTIVE falls back to IDLE only once every FIFO
    // will be empty after this edge and no producer is pushing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (errNow)
                    state_d = ST_ERROR;
                else if (!empty0 || !empty1 || !emptyO || push_D0 || push_D1)
                    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (errNow)
                    state_d = ST_ERROR;
                else if ((cnt0_d == '0) && (cnt1_d == '0) && (cntO_d == '0) &&
                         !push_D0 && !push_D1)
                    state_d = ST_IDLE;
            end
            default:   state_d = ST_ERROR;
        endcase
    end

    // All control state. Thresholds are sampled on every INIT cycle so the
    // value present when init drops is the one kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            cntO_q  <= '0;
            wr0_q   <= '0;
            rd0_q   <= '0;
            wr1_q   <= '0;
            rd1_q   <= '0;
            wrO_q   <= '0;
            rdO_q   <= '0;
            thrD_q  <= '0;
            thrO_q  <= '0;
            prio_q  <= 1'b0;
            error_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            cntO_q  <= cntO_d;
            if (state_q == ST_INIT) begin
                thrD_q <= Umbral_D_prob;
                thrO_q <= Umbral_O_prob;
            end
            if (wrEn0)
                wr0_q <= wr0_q + 1'b1;
            if (xfer0)
                rd0_q <= rd0_q + 1'b1;
            if (wrEn1)
                wr1_q <= wr1_q + 1'b1;
            if (xfer1)
                rd1_q <= rd1_q + 1'b1;
            if (doXfer) begin
                wrO_q  <= wrO_q + 1'b1;
                prio_q <= ~srcSel;
            end
            if (doPop) begin
                rdO_q  <= rdO_q + 1'b1;
                dout_q <= memO_q[rdO_q];
            end
            if (errNow)
                error_q <= 1'b1;
        end
    end

    // Storage arrays need no reset; emptiness is tracked by the counts.
    always_ff @(posedge clk) begin
        if (wrEn0)
            mem0_q[wr0_q] <= data_in0;
        if (wrEn1)
            mem1_q[wr1_q] <= data_in1;
        if (doXfer)
            memO_q[wrO_q] <= xferData;
    end

    // Pause flags are held low in RESET, where thresholds are still zero.
    assign D0_pause    = (state_q != ST_RESET) && (32'(cnt0_q) >= 32'(thrD_q));
    assign D1_pause    = (state_q != ST_RESET) && (32'(cnt1_q) >= 32'(thrD_q));
    assign Out_pause   = (state_q != ST_RESET) && (32'(cntO_q) >= 32'(thrO_q));
    assign out_can_pop = !emptyO;
    assign data_out    = dout_q;
    assign error_out   = error_q;
    assign idle_out    = (state_q == ST_IDLE);
    assign state       = state_q;
    assign next_state  = state_d;

endmodule

// File: tb/tb_pcie_trans_merge.sv
// Testbench for pcie_trans_merge: a queue-based reference model predicts
// counts, flags and FSM state each cycle; popped words go through a
// scoreboard queue and are compared when data_out updates.
module tb_pcie_trans_merge;

    logic       clk;
    logic       reset;
    logic       init;
    logic [5:0] data_in0;
    logic       push_D0;
    logic [5:0] data_in1;
    logic       push_D1;
    logic       pop_out;
    logic [3:0] Umbral_D_prob;
    logic [3:0] Umbral_O_prob;
    logic [5:0] data_out;
    logic       out_can_pop;
    logic       D0_pause;
    logic       D1_pause;
    logic       Out_pause;
    logic       error_out;
    logic       idle_out;
    logic [3:0] state;
    logic [3:0] next_state;

    int vecCount  = 0;
    int missCount = 0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [5:0] qo[$];
    logic [5:0] expQ[$];
    logic [5:0] got[$];
    int         mSt;
    bit         mPrio;
    bit         mErr;
    logic [5:0] mDout;
    int         mThrD;
    int         mThrO;
    bit         lastPop;

    pcie_trans_merge #(
        .BITNUMBER(6),
        .LENGTH(4),
        .IN_ADDR(2),
        .OUT_ADDR(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .init(init),
        .data_in0(data_in0),
        .push_D0(push_D0),
        .data_in1(data_in1),
        .push_D1(push_D1),
        .pop_out(pop_out),
        .Umbral_D_prob(Umbral_D_prob),
        .Umbral_O_prob(Umbral_O_prob),
        .data_out(data_out),
        .out_can_pop(out_can_pop),
        .D0_pause(D0_pause),
        .D1_pause(D1_pause),
        .Out_pause(Out_pause),
        .error_out(error_out),
        .idle_out(idle_out),
        .state(state),
        .next_state(next_state)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Compare all registered/flag outputs against the model.
    task automatic checkModelFlags();
        checkOutput("state", 32'(state), 32'(mSt));
        checkOutput("error_out", 32'(error_out), 32'(mErr));
        checkOutput("idle_out", 32'(idle_out), 32'(mSt == 2));
        checkOutput("out_can_pop", 32'(out_can_pop), 32'(qo.size() > 0));
        checkOutput("D0_pause", 32'(D0_pause), 32'((mSt != 0) && (q0.size() >= mThrD)));
        checkOutput("D1_pause", 32'(D1_pause), 32'((mSt != 0) && (q1.size() >= mThrD)));
        checkOutput("Out_pause", 32'(Out_pause), 32'((mSt != 0) && (qo.size() >= mThrO)));
    endtask

    // Drive one cycle of inputs, predict the next state before the edge,
    // then advance the model and compare after the edge.
    task automatic applyStimulus(input bit p0, input logic [5:0] d0, input bit p1,
                                 input logic [5:0] d1, input bit pop, input bit ini);
        int c0, c1, co, post0, post1, postO, nxt;
        bit act, doTr, src, doPop, udf, ovf0, ovf1, err, a0, a1;
        logic [5:0] w;
        @(negedge clk);
        push_D0  = p0;
        data_in0 = d0;
        push_D1  = p1;
        data_in1 = d1;
        pop_out  = pop;
        init     = ini;
        c0    = q0.size();
        c1    = q1.size();
        co    = qo.size();
        act   = (mSt == 2) || (mSt == 3);
        doTr  = act && (c0 > 0 || c1 > 0) && (co < 8 || pop);
        src   = (c0 > 0 && c1 > 0) ? mPrio : (c0 == 0);
        doPop = act && pop && (co > 0);
        udf   = act && pop && (co == 0);
        ovf0  = act && p0 && (c0 == 4) && !(doTr && !src);
        ovf1  = act && p1 && (c1 == 4) && !(doTr && src);
        err   = ovf0 || ovf1 || udf;
        a0    = act && p0 && !ovf0;
        a1    = act && p1 && !ovf1;
        post0 = c0 + int'(a0) - int'(doTr && !src);
        post1 = c1 + int'(a1) - int'(doTr && src);
        postO = co + int'(doTr) - int'(doPop);
        case (mSt)
            0: nxt = 1;
            1: nxt = ini ? 1 : 2;
            2: nxt = err ? 4 : ((c0 > 0 || c1 > 0 || co > 0 || p0 || p1) ? 3 : 2);
            3: nxt = err ? 4 : ((post0 == 0 && post1 == 0 && postO == 0 && !p0 && !p1) ? 2 : 3);
            default: nxt = 4;
        endcase
        #1;
        checkOutput("next_state", 32'(next_state), 32'(nxt));
        @(posedge clk);
        if (mSt == 1) begin
            mThrD = int'(Umbral_D_prob);
            mThrO = int'(Umbral_O_prob);
        end
        if (doPop) begin
            w = qo.pop_front();
            mDout = w;
            expQ.push_back(w);
        end
        if (doTr) begin
            if (src)
                w = q1.pop_front();
            else
                w = q0.pop_front();
            qo.push_back(w);
            mPrio = !src;
        end
        if (a0)
            q0.push_back(d0);
        if (a1)
            q1.push_back(d1);
        if (err)
            mErr = 1'b1;
        mSt     = nxt;
        lastPop = doPop;
        #1;
        checkModelFlags();
        if (doPop)
            checkOutput("data_out_pop", 32'(data_out), 32'(expQ.pop_front()));
        else
            checkOutput("data_out_hold", 32'(data_out), 32'(mDout));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic resetDut();
        @(negedge clk);
        #2;
        reset   = 1'b0;
        push_D0 = 1'b0;
        push_D1 = 1'b0;
        pop_out = 1'b0;
        init    = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        qo.delete();
        expQ.delete();
        mSt = 0; mPrio = 0; mErr = 0; mDout = '0; mThrD = 0; mThrO = 0; lastPop = 0;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_can_pop", 32'(out_can_pop), 32'd0);
        checkOutput("rst_D0_pause", 32'(D0_pause), 32'd0);
        checkOutput("rst_D1_pause", 32'(D1_pause), 32'd0);
        checkOutput("rst_Out_pause", 32'(Out_pause), 32'd0);
        checkOutput("rst_data_out", 32'(data_out), 32'd0);
        checkOutput("rst_error", 32'(error_out), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic initDut(input logic [3:0] thrD, input logic [3:0] thrO);
        Umbral_D_prob = thrD;
        Umbral_O_prob = thrO;
        applyStimulus(0, '0, 0, '0, 0, 1);
        applyStimulus(0, '0, 0, '0, 0, 1);
        applyStimulus(0, '0, 0, '0, 0, 0);
    endtask

    initial begin
        logic [5:0] altExp [6];
        altExp = '{6'h10, 6'h20, 6'h11, 6'h21, 6'h12, 6'h22};
        reset = 1'b0; init = 1'b0; push_D0 = 1'b0; push_D1 = 1'b0; pop_out = 1'b0;
        data_in0 = '0; data_in1 = '0; Umbral_D_prob = '0; Umbral_O_prob = '0;
        mSt = 0; mPrio = 0; mErr = 0; mDout = '0; mThrD = 0; mThrO = 0; lastPop = 0;

        // Three D0 words in, drained into egress, then popped in order.
        resetDut();
        initDut(4'd3, 4'd6);
        checkOutput("t2_idle", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 6'(i + 1), 0, '0, 0, 0);
        applyStimulus(0, '0, 0, '0, 0, 0);
        checkOutput("t2_out_pause_at3", 32'(Out_pause), 32'd0);
        checkOutput("t2_can_pop", 32'(out_can_pop), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, '0, 0, '0, 1, 0);
            checkOutput("t2_word", 32'(data_out), 32'(i + 1));
        end
        checkOutput("t2_back_idle", 32'(state), 32'd2);

        // Round-robin merge of two streams with continuous popping.
        resetDut();
        initDut(4'd3, 4'd6);
        got.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 6'h10 + 6'(i), 1, 6'h20 + 6'(i), qo.size() > 0, 0);
            if (lastPop) got.push_back(data_out);
        end
        for (int i = 0; i < 12 && got.size() < 6; i++) begin
            applyStimulus(0, '0, 0, '0, qo.size() > 0, 0);
            if (lastPop) got.push_back(data_out);
        end
        checkOutput("t3_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            checkOutput("t3_order", 32'(got[i]), 32'(altExp[i]));

        // Fill everything without popping until an ingress overflows.
        for (int i = 0; i < 30 && !mErr; i++)
            applyStimulus(1, 6'h30 + 6'(i % 8), 1, 6'h08 + 6'(i % 8), 0, 0);
        checkOutput("t4_error", 32'(error_out), 32'd1);
        checkOutput("t4_state", 32'(state), 32'd4);
        checkOutput("t4_out_pause", 32'(Out_pause), 32'd1);
        checkOutput("t4_D0_pause", 32'(D0_pause), 32'd1);

        // Underflow from IDLE, then pushes are ignored in ERROR.
        resetDut();
        initDut(4'd3, 4'd6);
        applyStimulus(0, '0, 0, '0, 1, 0);
        checkOutput("t5_error", 32'(error_out), 32'd1);
        checkOutput("t5_state", 32'(state), 32'd4);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 6'h05, 1, 6'h06, 0, 0);
        checkOutput("t5_ignored", 32'(out_can_pop), 32'd0);
        checkOutput("t5_no_pause", 32'(D0_pause), 32'd0);

        // Single D1 word: latency from push to pop.
        resetDut();
        initDut(4'd3, 4'd6);
        applyStimulus(0, '0, 1, 6'h2A, 0, 0);
        checkOutput("t6_active", 32'(state), 32'd3);
        checkOutput("t6_not_yet", 32'(out_can_pop), 32'd0);
        applyStimulus(0, '0, 0, '0, 0, 0);
        checkOutput("t6_can_pop", 32'(out_can_pop), 32'd1);
        applyStimulus(0, '0, 0, '0, 1, 0);
        checkOutput("t6_word", 32'(data_out), 32'h2A);
        checkOutput("t6_idle", 32'(state), 32'd2);

        // Reset while ACTIVE with three words buffered.
        resetDut();
        initDut(4'd3, 4'd6);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 6'h15 + 6'(i), 0, '0, 0, 0);
        checkOutput("t1_buffered", 32'(out_can_pop), 32'd1);
        resetDut();
        initDut(4'd3, 4'd6);
        checkOutput("t1_cleared", 32'(out_can_pop), 32'd0);
        checkOutput("t1_idle", 32'(state), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
